// File: rtl/d_ext_pipe.sv
// Buffered immediate extender for the D stage: extends at enqueue, holds {data, err} in a small FIFO.
// Optional feature: define EXT_BRANCH_EN to make opcode 011 produce a branch offset instead of an error.
module d_ext_pipe #(
    parameter int IMM_W  = 16,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [IMM_W-1:0]           in_imm,
    input  logic [2:0]                 in_op,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_err,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int K     = DATA_W - IMM_W;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_data [DEPTH];
    logic              mem_err  [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [DATA_W-1:0] zx_imm, sx_imm, ones_mask, ext_data;
    logic              ext_err;
    logic              enq, deq;

    assign zx_imm    = DATA_W'(in_imm);
    assign sx_imm    = DATA_W'($signed(in_imm));
    assign ones_mask = ~DATA_W'({IMM_W{1'b1}});

    always_comb begin
        ext_data = '1;
        ext_err  = 1'b1;
        case (in_op)
            3'b000: begin ext_data = zx_imm;             ext_err = 1'b0; end
            3'b001: begin ext_data = sx_imm;             ext_err = 1'b0; end
            3'b010: begin ext_data = zx_imm << K;        ext_err = 1'b0; end
`ifdef EXT_BRANCH_EN
            3'b011: begin ext_data = sx_imm << 2;        ext_err = 1'b0; end
`endif
            3'b100: begin ext_data = zx_imm | ones_mask; ext_err = 1'b0; end
            default: begin ext_data = '1;                ext_err = 1'b1; end
        endcase
    end

    // Handshake outputs come only from the registered count.
    assign in_ready  = (count < CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign out_data  = mem_data[rd_ptr];
    assign out_err   = mem_err[rd_ptr];

    assign enq = in_valid && in_ready && !flush;
    assign deq = out_valid && out_ready && !flush;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_err[i]  <= 1'b0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                mem_data[wr_ptr] <= ext_data;
                mem_err[wr_ptr]  <= ext_err;
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (deq) rd_ptr <= ptr_inc(rd_ptr);
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: doc/d_ext_pipe.md
# d_ext_pipe

Parametrised, buffered immediate-extension stage for the D pipeline stage. It succeeds the fixed 16→32 combinational extender. It accepts an immediate plus an extension opcode over a valid/ready handshake and computes the extended word at enqueue. The result is held in a small FIFO and presented to the consumer (operand mux / D→E pipeline register) over a second valid/ready handshake. It supports pipeline flush and flags illegal opcodes.

## Interface
Parameters:
- IMM_W, 16, immediate width; 1 ≤ IMM_W ≤ DATA_W.
- DATA_W, 32, extended result width.
- DEPTH, 2, FIFO entries; 1..8.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous flush; empties the FIFO.
- in_valid  in  1  producer has an immediate.
- in_ready  out  1  block can accept; equals count < DEPTH.
- in_imm  in  IMM_W  raw immediate.
- in_op  in  3  extension opcode.
- out_valid  out  1  head entry valid; equals count != 0.
- out_ready  in  1  consumer takes the head entry.
- out_data  out  DATA_W  head entry result.
- out_err  out  1  head entry was produced from an illegal opcode.
- count  out  $clog2(DEPTH+1)  current occupancy.

## Operation
- Enqueue when in_valid && in_ready && !flush. Dequeue when out_valid && out_ready && !flush.
- Result is computed combinationally from in_imm/in_op and written into the entry at enqueue. The stored {data, err} pair is never recomputed.
- Opcodes (K = DATA_W − IMM_W):
  - 000 zero-extend: {K'0, imm}.
  - 001 sign-extend: {K{imm[IMM_W-1]}, imm}.
  - 010 upper-load: imm shifted left by K, low K bits zero. When K = 0, the result is imm.
  - 011 branch offset: sign-extend, then shift left 2, truncated to DATA_W. Only legal with the macro; see Configuration.
  - 100 ones-extend: {K'1s, imm}.
  - All other codes: result all ones (DATA_W'1), err = 1.
- FIFO behaviour:
  - Circular FIFO with write and read pointers; both wrap at DEPTH, including non-power-of-two DEPTH.
  - Simultaneous enqueue and dequeue: count unchanged. This is only possible while not full, because in_ready is low when full, even if out_ready is high.
  - Empty: out_valid = 0, and out_data/out_err show the stale read-pointer entry. The consumer must ignore them.
  - Full: in_ready = 0; the producer must hold its input.
- Flush has priority over everything:
  - Pointers and count are cleared.
  - An input presented in the flush cycle is dropped.
  - No dequeue is counted in the flush cycle.

## Timing
- Reset (reset_n low, asynchronous): count = 0, pointers = 0, all entries = 0. Resulting outputs: out_valid = 0, out_data = 0, out_err = 0, in_ready = 1.
- Latency: an input accepted on edge N into an empty FIFO gives out_valid = 1 with its data after edge N. There is no combinational in→out bypass.
- Throughput: one entry per cycle when DEPTH ≥ 2 and the consumer is always ready. With DEPTH = 1, the rate is one entry every 2 cycles.
- in_ready and out_valid are decoded from registered count only; neither depends combinationally on any input.
- Reset asserted mid-transfer: the entry is discarded. After reset_n rises, the first edge may enqueue.
- After flush on edge N, the FIFO is empty and in_ready = 1.

## Configuration
- EXT_BRANCH_EN defined: opcode 011 produces the branch offset, err = 0.
- EXT_BRANCH_EN undefined: opcode 011 is illegal, giving all ones with err = 1. All other behaviour is identical.

## Test plan
- Reset, then enqueue imm = 16'h8001 with each op 000/001/010/100. Required out_data in order: 32'h0000_8001, 32'hFFFF_8001, 32'h8001_0000, 32'hFFFF_8001, all with out_err = 0.
- Enqueue op 011 with imm = 16'hFFFF:
  - With EXT_BRANCH_EN: 32'hFFFF_FFFC, out_err = 0.
  - Without it: 32'hFFFF_FFFF, out_err = 1.
- Enqueue op 111 with imm = 16'h1234 → out_data = 32'hFFFF_FFFF, out_err = 1.
- DEPTH = 2, out_ready = 0:
  - Enqueue A, then B → count = 2, in_ready = 0, and a third input is held.
  - Set out_ready = 1 → A, B, then the held third input are delivered in order.
- Keep the FIFO at count = 1 and do simultaneous enqueue and dequeue for 10 cycles → count stays 1, data stays in order, pointers wrap correctly.
- With count = 2, assert flush together with in_valid → count = 0 and out_valid = 0 the next cycle, and the flushed-cycle input is absent.
- Assert reset_n low asynchronously between edges → out_valid, out_data, out_err and count are 0 before the next edge.
